// File: rtl/sd_card_data_phy.sv
`default_nettype none
// sd_card_data_phy: card-side DAT0 engine (write-block receive with CRC token/busy, read-block transmit).
// Define SD_CARD_CRC_EN to generate/check CRC16; otherwise the CRC field is sent as zero and ignored on receive.
module sd_card_data_phy #(
  parameter int BLOCK_LEN   = 512,
  parameter int BUSY_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DAT_IN,
  output logic       DAT_OUT,
  output logic       DAT_OE,
  input  logic       RX_START,
  input  logic       TX_START,
  input  logic [7:0] TX_DATA,
  output logic       TX_RD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_CRC_OK,
  output logic       DONE,
  output logic       BUSY
);

  localparam int BYTE_W  = $clog2(BLOCK_LEN + 1);
  localparam int AUX_MAX = (BUSY_CYCLES > 16) ? BUSY_CYCLES : 16;
  localparam int AUX_W   = $clog2(AUX_MAX + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BLOCK_LEN - 1);
  localparam logic [AUX_W-1:0]  CRC_LAST  = AUX_W'(15);
  localparam logic [AUX_W-1:0]  TURN_LAST = AUX_W'(1);
  localparam logic [AUX_W-1:0]  TOK_LAST  = AUX_W'(4);
  localparam logic [AUX_W-1:0]  BUSY_LAST = AUX_W'(BUSY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_WAIT,
    S_RX_DATA,
    S_RX_CRC,
    S_RX_END,
    S_TURN,
    S_TOKEN,
    S_WBUSY,
    S_TX_SB,
    S_TX_DATA,
    S_TX_CRC,
    S_TX_EB
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [AUX_W-1:0]  aux_cnt;
  logic [7:0]        tx_shift;
  logic [6:0]        rx_shift;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q;
  logic              rx_crc_ok_q;
  logic              done_q;
  logic              dat_out_c;
  logic              dat_oe_c;
  logic              tx_rd_c;
  logic              token_bit;
  logic              crc_msb;
  logic              crc_match;
  logic [2:0]        status;

`ifdef SD_CARD_CRC_EN
  logic [15:0] crc;
  logic [15:0] rx_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // One LFSR serves both directions; it is cleared while waiting for a block to begin.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      crc    <= '0;
      rx_crc <= '0;
    end else begin
      case (state)
        S_RX_WAIT, S_TX_SB: crc    <= '0;
        S_RX_DATA:          crc    <= crc_step(crc, DAT_IN);
        S_RX_CRC:           rx_crc <= {rx_crc[14:0], DAT_IN};
        S_TX_DATA:          crc    <= crc_step(crc, tx_shift[7]);
        S_TX_CRC:           crc    <= {crc[14:0], 1'b0};
        default: ;
      endcase
    end
  end

  assign crc_msb   = crc[15];
  assign crc_match = (rx_crc == crc);
`else
  assign crc_msb   = 1'b0;
  assign crc_match = 1'b1;
`endif

  assign status = rx_crc_ok_q ? 3'b010 : 3'b101;

  always_comb begin
    token_bit = 1'b1;
    if (aux_cnt == '0)                token_bit = 1'b0;
    else if (aux_cnt == AUX_W'(1))    token_bit = status[2];
    else if (aux_cnt == AUX_W'(2))    token_bit = status[1];
    else if (aux_cnt == AUX_W'(3))    token_bit = status[0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dat_oe_c  = 1'b0;
    dat_out_c = 1'b1;
    tx_rd_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (TX_START)      state_nxt = S_TX_SB;
        else if (RX_START) state_nxt = S_RX_WAIT;
      end
      S_RX_WAIT: if (!DAT_IN) state_nxt = S_RX_DATA;
      S_RX_DATA: if (bit_cnt == 3'd7 && byte_cnt == LAST_BYTE) state_nxt = S_RX_CRC;
      S_RX_CRC:  if (aux_cnt == CRC_LAST) state_nxt = S_RX_END;
      S_RX_END:  state_nxt = S_TURN;
      S_TURN:    if (aux_cnt == TURN_LAST) state_nxt = S_TOKEN;
      S_TOKEN: begin
        dat_oe_c  = 1'b1;
        dat_out_c = token_bit;
        if (aux_cnt == TOK_LAST) state_nxt = S_WBUSY;
      end
      S_WBUSY: begin
        dat_oe_c  = 1'b1;
        dat_out_c = 1'b0;
        if (aux_cnt == BUSY_LAST) state_nxt = S_IDLE;
      end
      S_TX_SB: begin
        dat_oe_c  = 1'b1;
        dat_out_c = 1'b0;
        tx_rd_c   = 1'b1;
        state_nxt = S_TX_DATA;
      end
      S_TX_DATA: begin
        dat_oe_c  = 1'b1;
        dat_out_c = tx_shift[7];
        if (bit_cnt == 3'd7) begin
          if (byte_cnt == LAST_BYTE) state_nxt = S_TX_CRC;
          else                       tx_rd_c   = 1'b1;
        end
      end
      S_TX_CRC: begin
        dat_oe_c  = 1'b1;
        dat_out_c = crc_msb;
        if (aux_cnt == CRC_LAST) state_nxt = S_TX_EB;
      end
      S_TX_EB: begin
        dat_oe_c  = 1'b1;
        dat_out_c = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // aux_cnt restarts on every state change and times the CRC, turnaround, token and busy phases.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      aux_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_crc_ok_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= (state != S_IDLE) && (state_nxt == S_IDLE);
      aux_cnt    <= (state_nxt != state) ? '0 : aux_cnt + AUX_W'(1);
      case (state)
        S_IDLE: if (RX_START && !TX_START) rx_crc_ok_q <= 1'b0;
        S_RX_WAIT: begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        S_RX_DATA: begin
          rx_shift <= {rx_shift[5:0], DAT_IN};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_q  <= {rx_shift, DAT_IN};
            rx_valid_q <= 1'b1;
            byte_cnt   <= byte_cnt + BYTE_W'(1);
          end
        end
        S_RX_END: rx_crc_ok_q <= crc_match & DAT_IN;
        S_TX_SB: begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
          tx_shift <= TX_DATA;
        end
        S_TX_DATA: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + BYTE_W'(1);
            if (tx_rd_c) tx_shift <= TX_DATA;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign DAT_OUT   = dat_out_c;
  assign DAT_OE    = dat_oe_c;
  assign TX_RD     = tx_rd_c;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_CRC_OK = rx_crc_ok_q;
  assign DONE      = done_q;
  assign BUSY      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_card_data_phy.sv
`default_nettype none
// Bench for sd_card_data_phy: table of write/read blocks checked against a bit-stream model
// whose CRC16 is obtained by polynomial long division.
module tb_sd_card_data_phy;

  localparam int L      = 512;
  localparam int BUSY_N = 8;
  localparam int NBITS  = L * 8 + 18;
`ifdef SD_CARD_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef logic [7:0] blk_t [L];

  typedef struct {
    bit         is_tx;
    bit         rnd;
    logic [7:0] fill;
    bit         bad_crc;
    bit         end_bit;
    bit         exp_ok;
    bit         chk_const;
    logic [15:0] const_crc;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DAT_IN;
  logic       DAT_OUT;
  logic       DAT_OE;
  logic       RX_START;
  logic       TX_START;
  logic [7:0] TX_DATA;
  logic       TX_RD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_CRC_OK;
  logic       DONE;
  logic       BUSY;

  int   checks = 0;
  int   errors = 0;
  blk_t data_blk;
  vec_t vecs [8];

  sd_card_data_phy #(.BLOCK_LEN(L), .BUSY_CYCLES(BUSY_N)) dut (
    .CLK(CLK), .RESET(RESET), .DAT_IN(DAT_IN), .DAT_OUT(DAT_OUT), .DAT_OE(DAT_OE),
    .RX_START(RX_START), .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_RD(TX_RD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_CRC_OK(RX_CRC_OK), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] model_crc(input blk_t d);
    logic        m [L*8+16];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    for (int i = 0; i < L*8+16; i++) m[i] = 1'b0;
    for (int i = 0; i < L; i++)
      for (int b = 0; b < 8; b++) m[i*8+b] = d[i][7-b];
    for (int i = 0; i < L*8; i++)
      if (m[i]) for (int k = 0; k < 17; k++) m[i+k] = m[i+k] ^ g[16-k];
    for (int k = 0; k < 16; k++) r[15-k] = m[L*8+k];
    return r;
  endfunction

  task automatic do_tx(input bit rnd, input logic [7:0] fill, input bit with_rx,
                       input bit chk_const, input logic [15:0] const_crc);
    logic        ebits [NBITS];
    logic [15:0] mcrc, sent_crc, got_crc;
    int mism, rd_bad, rd_cnt, oe_bad, busy_bad, rxv, dn;
    mism = 0; rd_bad = 0; rd_cnt = 0; oe_bad = 0; busy_bad = 0; rxv = 0; dn = 0;
    got_crc = '0;
    for (int i = 0; i < L; i++) data_blk[i] = rnd ? 8'($urandom) : fill;
    mcrc     = model_crc(data_blk);
    sent_crc = CRC_EN ? mcrc : 16'h0000;
    ebits[0] = 1'b0;
    for (int i = 0; i < L; i++)
      for (int b = 0; b < 8; b++) ebits[1+i*8+b] = data_blk[i][7-b];
    for (int k = 0; k < 16; k++) ebits[1+8*L+k] = sent_crc[15-k];
    ebits[NBITS-1] = 1'b1;

    @(posedge CLK); #1;
    TX_START = 1'b1; RX_START = with_rx; TX_DATA = 8'($urandom);
    @(posedge CLK); #1;
    TX_START = 1'b0; RX_START = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      if (DAT_OE !== 1'b1) oe_bad++;
      if (DAT_OUT !== ebits[i]) mism++;
      if (i > 8*L && i <= 8*L+16) got_crc = {got_crc[14:0], DAT_OUT};
      if (TX_RD !== ((i % 8 == 0) && (i / 8 < L))) rd_bad++;
      if (RX_VALID === 1'b1) rxv++;
      if (DONE === 1'b1) dn++;
      if (BUSY !== 1'b1) busy_bad++;
      RX_START = (i == 30);
      if (TX_RD === 1'b1) begin
        TX_DATA = (rd_cnt < L) ? data_blk[rd_cnt] : 8'($urandom);
        rd_cnt++;
      end else begin
        TX_DATA = 8'($urandom);
      end
      @(posedge CLK); #1;
    end
    RX_START = 1'b0;
    chk("tx_end_oe", DAT_OE, 0);
    chk("tx_end_out", DAT_OUT, 1);
    chk("tx_done", DONE, 1);
    chk("tx_end_busy", BUSY, 0);
    @(posedge CLK); #1;
    chk("tx_done_width", DONE, 0);
    chk("tx_stream_bit_errors", mism, 0);
    chk("tx_crc_field", got_crc, sent_crc);
    if (chk_const) chk("tx_crc_constant", got_crc, const_crc);
    chk("tx_rd_position_errors", rd_bad, 0);
    chk("tx_rd_count", rd_cnt, L);
    chk("tx_oe_drop", oe_bad, 0);
    chk("tx_busy_drop", busy_bad, 0);
    chk("tx_spurious_rx_valid", rxv, 0);
    chk("tx_early_done", dn, 0);
  endtask

  task automatic do_rx(input bit rnd, input logic [7:0] fill, input bit bad_crc,
                       input bit end_bit, input bit exp_ok);
    logic        hb [NBITS];
    logic        tok [5];
    logic [15:0] sent_crc;
    logic        exp_v, exp_oe, exp_out;
    int gap, vbad, dbad, nbytes, oe_bad, dn, wbad;
    vbad = 0; dbad = 0; nbytes = 0; oe_bad = 0; dn = 0; wbad = 0;
    for (int i = 0; i < L; i++) data_blk[i] = rnd ? 8'($urandom) : fill;
    sent_crc = model_crc(data_blk) ^ {15'd0, bad_crc};
    hb[0] = 1'b0;
    for (int i = 0; i < L; i++)
      for (int b = 0; b < 8; b++) hb[1+i*8+b] = data_blk[i][7-b];
    for (int k = 0; k < 16; k++) hb[1+8*L+k] = sent_crc[15-k];
    hb[NBITS-1] = end_bit;
    tok[0] = 1'b0; tok[4] = 1'b1;
    tok[1] = !exp_ok; tok[2] = exp_ok; tok[3] = !exp_ok;

    @(posedge CLK); #1;
    RX_START = 1'b1;
    @(posedge CLK); #1;
    RX_START = 1'b0;
    chk("rx_crc_ok_cleared", RX_CRC_OK, 0);
    chk("rx_busy_armed", BUSY, 1);
    gap = $urandom_range(0, 4);
    for (int g = 0; g < gap; g++) begin
      if (DAT_OE !== 1'b0) oe_bad++;
      @(posedge CLK); #1;
    end
    for (int j = 0; j < NBITS; j++) begin
      DAT_IN   = hb[j];
      TX_START = (j == 50);
      exp_v = (j >= 9) && ((j - 9) % 8 == 0) && ((j - 9) / 8 < L);
      if (RX_VALID !== exp_v) vbad++;
      if (RX_VALID === 1'b1) begin
        if (nbytes < L && RX_DATA !== data_blk[nbytes]) dbad++;
        nbytes++;
      end
      if (DAT_OE !== 1'b0 || DAT_OUT !== 1'b1) oe_bad++;
      if (DONE === 1'b1) dn++;
      @(posedge CLK); #1;
    end
    TX_START = 1'b0;
    DAT_IN   = 1'b1;
    chk("rx_crc_ok_result", RX_CRC_OK, exp_ok);
    for (int p = 0; p < 7 + BUSY_N; p++) begin
      exp_oe  = (p >= 2);
      exp_out = (p < 2) ? 1'b1 : (p < 7) ? tok[p-2] : 1'b0;
      if (DAT_OE !== exp_oe || DAT_OUT !== exp_out) wbad++;
      if (DONE === 1'b1) dn++;
      @(posedge CLK); #1;
    end
    chk("rx_done", DONE, 1);
    chk("rx_end_oe", DAT_OE, 0);
    chk("rx_end_out", DAT_OUT, 1);
    chk("rx_end_busy", BUSY, 0);
    chk("rx_valid_position_errors", vbad, 0);
    chk("rx_byte_count", nbytes, L);
    chk("rx_data_errors", dbad, 0);
    chk("rx_bus_driven_early", oe_bad, 0);
    chk("rx_early_done", dn, 0);
    chk("rx_token_busy_errors", wbad, 0);
    @(posedge CLK); #1;
    chk("rx_done_width", DONE, 0);
    chk("rx_crc_ok_held", RX_CRC_OK, exp_ok);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, CRC_EN ? 16'h7FA1 : 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, !CRC_EN, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, !CRC_EN, 1'b0, 16'h0000};

    RESET = 1'b1; DAT_IN = 1'b1; RX_START = 1'b0; TX_START = 1'b0; TX_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_dat_out", DAT_OUT, 1);
    chk("reset_dat_oe", DAT_OE, 0);
    chk("reset_tx_rd", TX_RD, 0);
    chk("reset_rx_data", RX_DATA, 0);
    chk("reset_rx_valid", RX_VALID, 0);
    chk("reset_rx_crc_ok", RX_CRC_OK, 0);
    chk("reset_done", DONE, 0);
    chk("reset_busy", BUSY, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_busy", BUSY, 0);

    // RX_START together with TX_START: the read block must win.
    do_tx(1'b1, 8'h00, 1'b1, 1'b0, 16'h0000);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_tx) do_tx(vecs[v].rnd, vecs[v].fill, 1'b0, vecs[v].chk_const, vecs[v].const_crc);
      else               do_rx(vecs[v].rnd, vecs[v].fill, vecs[v].bad_crc, vecs[v].end_bit, vecs[v].exp_ok);
    end

    // Reset in the middle of byte 100 of a read block.
    @(posedge CLK); #1;
    TX_START = 1'b1;
    @(posedge CLK); #1;
    TX_START = 1'b0;
    for (int i = 0; i < 1 + 8*100 + 3; i++) begin
      TX_DATA = 8'($urandom);
      @(posedge CLK); #1;
    end
    chk("mid_tx_busy", BUSY, 1);
    chk("mid_tx_oe", DAT_OE, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("reset_mid_tx_oe", DAT_OE, 0);
    chk("reset_mid_tx_out", DAT_OUT, 1);
    chk("reset_mid_tx_busy", BUSY, 0);
    chk("reset_mid_tx_done", DONE, 0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (DONE !== 1'b0 || DAT_OE !== 1'b0 || BUSY !== 1'b0) bad++;
        @(posedge CLK); #1;
      end
      chk("post_reset_quiet", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
